// File: rtl/cam_init_pkg.sv
// Shared definitions for the camera register-initialisation sequencer.
//
// Contents:
//   state_t   - sequencer FSM states
//   CMD_*     - encodings driven on iic_cmd towards the IIC master
//   max_u     - elaboration-time helper used to size the shared delay counter
package cam_init_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PWRUP,
        WRITE,
        VERIFY,
        GAP,
        DONE,
        FAIL
    } state_t;

    localparam logic [1:0] CMD_IDLE  = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_READ  = 2'b01;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cam_init_seq_if.sv
// IIC master / config LUT ROM link used by cam_init_seq.
//
// Signals:
//   iic_cmd    - command to the IIC master (00 idle, 10 write, 01 read)
//   write_done - one-cycle pulse, current IIC write finished
//   iic_ack    - 0 = ACK, 1 = NACK, valid with write_done/read_done
//   lut_index  - current LUT ROM address
//   read_done, rd_data, lut_data - read-back path, only present when
//                CAM_INIT_VERIFY_EN is defined
//
// Modports:
//   master - the sequencer side
//   slave  - the IIC master / LUT ROM side
interface cam_init_seq_if #(
    parameter int unsigned IDX_W = 8
);

    logic [1:0]       iic_cmd;
    logic             write_done;
    logic             iic_ack;
    logic [IDX_W-1:0] lut_index;

`ifdef CAM_INIT_VERIFY_EN
    logic             read_done;
    logic [7:0]       rd_data;
    logic [7:0]       lut_data;

    modport master (
        output iic_cmd,
        output lut_index,
        input  write_done,
        input  iic_ack,
        input  read_done,
        input  rd_data,
        input  lut_data
    );

    modport slave (
        input  iic_cmd,
        input  lut_index,
        output write_done,
        output iic_ack,
        output read_done,
        output rd_data,
        output lut_data
    );
`else
    modport master (
        output iic_cmd,
        output lut_index,
        input  write_done,
        input  iic_ack
    );

    modport slave (
        input  iic_cmd,
        input  lut_index,
        output write_done,
        output iic_ack
    );
`endif

endinterface

// File: rtl/cam_delay_cnt.sv
// Loadable down-counter shared by the power-up wait and the inter-transfer gap.
//
// Ports:
//   clk_100M - system clock
//   rst_n    - synchronous active-low reset (count cleared to 0)
//   en       - clock enable; 0 freezes the count
//   load     - load load_val (takes priority over counting)
//   load_val - value to load; the terminal pulse comes after that many cycles
//   tc       - terminal pulse, high for the enabled cycle in which the count is 1
module cam_delay_cnt #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_100M,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_100M) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (en) begin
            if (load) begin
                cnt_q <= load_val;
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    // Count stops at 0, so tc fires once per load.
    assign tc = en && !load && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/cam_init_seq.sv
// Camera register-initialisation sequencer.
//
// Walks LUT indices LUT_START..LUT_END (inclusive), issuing one IIC write per
// entry. NACKed entries are rewritten up to MAX_RETRY times before the
// sequence stops in FAIL with the failing index latched. Every transfer is
// followed by max(GAP_CYCLES,1) idle cycles; the first write waits
// max(PWRUP_CYCLES,1) cycles after device_done.
//
// Optional feature: define CAM_INIT_VERIFY_EN to read back every ACKed write
// and compare it against the LUT data; a NACK or mismatch on the read counts
// as a retry of the same entry.
//
// Ports:
//   clk_100M    - system clock
//   rst_n       - synchronous active-low reset
//   en          - clock enable; 0 freezes all state and outputs
//   start       - one-cycle pulse, restarts the sequence from DONE or FAIL
//   device_done - IIC master / camera ready (level, only looked at in IDLE)
//   bus         - IIC master and LUT ROM link (cam_init_seq_if.master)
//   busy        - sequence in progress
//   done        - all entries written OK (sticky until start/reset)
//   error       - retries exhausted (sticky until start/reset)
//   err_index   - failing LUT index, valid while error=1
//
// LUT_END must be >= LUT_START and < 2**IDX_W.
module cam_init_seq
    import cam_init_pkg::*;
#(
    parameter int unsigned IDX_W        = 8,
    parameter int unsigned LUT_START    = 2,
    parameter int unsigned LUT_END      = 169,
    parameter int unsigned MAX_RETRY    = 3,
    parameter int unsigned PWRUP_CYCLES = 100000,
    parameter int unsigned GAP_CYCLES   = 1000
) (
    input  logic             clk_100M,
    input  logic             rst_n,
    input  logic             en,
    input  logic             start,
    input  logic             device_done,
    cam_init_seq_if.master   bus,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [IDX_W-1:0] err_index
);

    // A zero cycle count would never produce a terminal pulse, so clamp to 1.
    localparam int unsigned PWR_LOAD = (PWRUP_CYCLES == 0) ? 1 : PWRUP_CYCLES;
    localparam int unsigned GAP_LOAD = (GAP_CYCLES == 0) ? 1 : GAP_CYCLES;
    localparam int unsigned DLY_W    = $clog2(max_u(PWR_LOAD, GAP_LOAD) + 1);
    localparam int unsigned RETRY_W  = (MAX_RETRY == 0) ? 1 : $clog2(MAX_RETRY + 1);

    state_t             state_q;
    logic [1:0]         cmd_q;
    logic [IDX_W-1:0]   idx_q;
    logic               busy_q;
    logic               done_q;
    logic               error_q;
    logic [IDX_W-1:0]   err_idx_q;
    logic [RETRY_W-1:0] retry_q;
    logic               advance_q;

    logic               xfer_end;
    logic               xfer_ok;
    logic               go_verify;
    logic               dly_load;
    logic [DLY_W-1:0]   dly_val;
    logic               dly_tc;

    // End and outcome of the transfer currently in flight. A write and a
    // read-back share the same retry rules, so they are folded together here.
    always_comb begin
        xfer_end  = 1'b0;
        xfer_ok   = 1'b0;
        go_verify = 1'b0;
        if (state_q == WRITE) begin
            xfer_end = bus.write_done;
            xfer_ok  = !bus.iic_ack;
`ifdef CAM_INIT_VERIFY_EN
            go_verify = 1'b1;
`endif
        end
`ifdef CAM_INIT_VERIFY_EN
        else if (state_q == VERIFY) begin
            xfer_end = bus.read_done;
            xfer_ok  = !bus.iic_ack && (bus.rd_data == bus.lut_data);
        end
`endif
    end

    // Counter loads mirror the FSM transitions that enter PWRUP or GAP. A load
    // on an ACKed write that moves to VERIFY is harmless: VERIFY ignores the
    // counter and read_done reloads it.
    always_comb begin
        dly_load = 1'b0;
        dly_val  = DLY_W'(GAP_LOAD);
        case (state_q)
            IDLE: begin
                if (device_done) begin
                    dly_load = 1'b1;
                    dly_val  = DLY_W'(PWR_LOAD);
                end
            end
            WRITE, VERIFY: dly_load = xfer_end;
            DONE, FAIL:    dly_load = start;
            default:       dly_load = 1'b0;
        endcase
    end

    cam_delay_cnt #(
        .CNT_W(DLY_W)
    ) u_delay_cnt (
        .clk_100M(clk_100M),
        .rst_n   (rst_n),
        .en      (en),
        .load    (dly_load),
        .load_val(dly_val),
        .tc      (dly_tc)
    );

    // Outputs are registered together with the state, so iic_cmd changes on
    // the same edge as the transition that causes it.
    always_ff @(posedge clk_100M) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cmd_q     <= CMD_IDLE;
            idx_q     <= IDX_W'(LUT_START);
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            err_idx_q <= '0;
            retry_q   <= '0;
            advance_q <= 1'b0;
        end else if (en) begin
            case (state_q)
                IDLE: begin
                    if (device_done) begin
                        state_q <= PWRUP;
                        busy_q  <= 1'b1;
                    end
                end

                PWRUP: begin
                    if (dly_tc) begin
                        state_q <= WRITE;
                        cmd_q   <= CMD_WRITE;
                    end
                end

                WRITE, VERIFY: begin
                    if (xfer_end) begin
                        if (xfer_ok && go_verify) begin
                            state_q <= VERIFY;
                            cmd_q   <= CMD_READ;
                        end else if (xfer_ok) begin
                            state_q   <= GAP;
                            cmd_q     <= CMD_IDLE;
                            advance_q <= 1'b1;
                            retry_q   <= '0;
                        end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
                            state_q   <= GAP;
                            cmd_q     <= CMD_IDLE;
                            advance_q <= 1'b0;
                            retry_q   <= retry_q + RETRY_W'(1);
                        end else begin
                            state_q   <= FAIL;
                            cmd_q     <= CMD_IDLE;
                            busy_q    <= 1'b0;
                            error_q   <= 1'b1;
                            err_idx_q <= idx_q;
                        end
                    end
                end

                GAP: begin
                    if (dly_tc) begin
                        if (!advance_q) begin
                            state_q <= WRITE;
                            cmd_q   <= CMD_WRITE;
                        end else if (idx_q == IDX_W'(LUT_END)) begin
                            // End check before increment: the index never wraps.
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= WRITE;
                            cmd_q   <= CMD_WRITE;
                            idx_q   <= idx_q + IDX_W'(1);
                        end
                    end
                end

                DONE, FAIL: begin
                    if (start) begin
                        // Restart through a gap so the bus sees idle before
                        // the first write of the new pass.
                        state_q   <= GAP;
                        cmd_q     <= CMD_IDLE;
                        idx_q     <= IDX_W'(LUT_START);
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        error_q   <= 1'b0;
                        retry_q   <= '0;
                        advance_q <= 1'b0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    cmd_q   <= CMD_IDLE;
                end
            endcase
        end
    end

    assign bus.iic_cmd   = cmd_q;
    assign bus.lut_index = idx_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign err_index     = err_idx_q;

endmodule
